// File: rtl/l2_harness_pkg.sv
// Shared definitions for the L2 harness: OpenPiton header field positions,
// message type codes, the injector state encoding and a header builder.
package l2_harness_pkg;

  localparam int FLIT_W     = 64;
  localparam int REQ_DATA_W = 128;

  // Header flit field positions
  localparam int HDR_CHIPID_HI = 63;
  localparam int HDR_CHIPID_LO = 50;
  localparam int HDR_X_HI      = 49;
  localparam int HDR_X_LO      = 42;
  localparam int HDR_Y_HI      = 41;
  localparam int HDR_Y_LO      = 34;
  localparam int HDR_FBITS_HI  = 33;
  localparam int HDR_FBITS_LO  = 30;
  localparam int HDR_LEN_HI    = 29;
  localparam int HDR_LEN_LO    = 22;
  localparam int HDR_TYPE_HI   = 21;
  localparam int HDR_TYPE_LO   = 14;
  localparam int HDR_MSHR_HI   = 13;
  localparam int HDR_MSHR_LO   = 6;
  localparam int HDR_OPT_HI    = 5;
  localparam int HDR_OPT_LO    = 0;

  // Message type codes
  localparam logic [7:0] MSG_TYPE_LOAD_MEM_ACK  = 8'd24;
  localparam logic [7:0] MSG_TYPE_STORE_MEM_ACK = 8'd25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } inj_state_e;

  // Assemble a header flit; fbits and options are always zero.
  function automatic logic [FLIT_W-1:0] build_header(
    input logic [13:0] chipid,
    input logic [7:0]  x,
    input logic [7:0]  y,
    input logic [7:0]  len,
    input logic [7:0]  msg_type,
    input logic [7:0]  mshrid
  );
    logic [FLIT_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_CHIPID_HI:HDR_CHIPID_LO] = chipid;
    hdr[HDR_X_HI:HDR_X_LO]           = x;
    hdr[HDR_Y_HI:HDR_Y_LO]           = y;
    hdr[HDR_LEN_HI:HDR_LEN_LO]       = len;
    hdr[HDR_TYPE_HI:HDR_TYPE_LO]     = msg_type;
    hdr[HDR_MSHR_HI:HDR_MSHR_LO]     = mshrid;
    return hdr;
  endfunction

endpackage

// File: rtl/l2_noc_msg_injector_if.sv
// Request and NoC-side signals of the message injector. The master modport
// is the injector's view; the slave modport is the harness/L2 view.
interface l2_noc_msg_injector_if;
  import l2_harness_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [7:0]            req_type;
  logic [7:0]            req_mshrid;
  logic [7:0]            req_len;
  logic [13:0]           req_chipid;
  logic [7:0]            req_x;
  logic [7:0]            req_y;
  logic [REQ_DATA_W-1:0] req_data;
  logic                  noc_valid_out;
  logic [FLIT_W-1:0]     noc_data_out;
  logic                  noc_ready_in;
  logic                  issue_pulse;
  logic                  done_pulse;
  logic                  len_err;
  logic                  stall_timeout;

  modport master (
    input  req_valid, req_type, req_mshrid, req_len, req_chipid, req_x, req_y,
           req_data, noc_ready_in,
    output req_ready, noc_valid_out, noc_data_out, issue_pulse, done_pulse,
           len_err, stall_timeout
  );

  modport slave (
    output req_valid, req_type, req_mshrid, req_len, req_chipid, req_x, req_y,
           req_data, noc_ready_in,
    input  req_ready, noc_valid_out, noc_data_out, issue_pulse, done_pulse,
           len_err, stall_timeout
  );

endinterface

// File: rtl/l2_noc_msg_injector.sv
// Serializes one abstract coherence message into OpenPiton flits (header
// plus up to MAX_PAYLOAD payload words) and drives them into an L2 NoC
// port under valid/ready. One message in flight; all outputs registered.
module l2_noc_msg_injector
  import l2_harness_pkg::*;
#(
  parameter int MAX_PAYLOAD = 2,
  parameter int STALL_LIMIT = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  l2_noc_msg_injector_if.master  bus
);

  localparam logic [7:0] MAX_LEN   = 8'(MAX_PAYLOAD);
  localparam logic [7:0] STALL_LIM = 8'(STALL_LIMIT);

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  inj_state_e             state;
  logic [7:0]             len_q;
  logic [7:0]             idx_q;
  logic [7:0]             idx_nxt;
  logic [7:0]             stall_cnt;
  logic [7:0]             stall_inc;
  logic [1:0][FLIT_W-1:0] data_q;

  logic              req_ready_q;
  logic              noc_valid_q;
  logic [FLIT_W-1:0] noc_data_q;
  logic              issue_q;
  logic              done_q;
  logic              len_err_q;
  logic              stall_timeout_q;

  assign idx_nxt   = idx_q + 8'd1;
  assign stall_inc = sat_inc(stall_cnt);

  assign bus.req_ready     = req_ready_q;
  assign bus.noc_valid_out = noc_valid_q;
  assign bus.noc_data_out  = noc_data_q;
  assign bus.issue_pulse   = issue_q;
  assign bus.done_pulse    = done_q;
  assign bus.len_err       = len_err_q;
  assign bus.stall_timeout = stall_timeout_q;

  // Capture payload words only in the accepting cycle; data needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.req_valid) begin
      data_q <= bus.req_data;
    end
  end

  // Message FSM: accept, emit header, emit payload words, flag stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      len_q           <= 8'd0;
      idx_q           <= 8'd0;
      stall_cnt       <= 8'd0;
      req_ready_q     <= 1'b1;
      noc_valid_q     <= 1'b0;
      noc_data_q      <= '0;
      issue_q         <= 1'b0;
      done_q          <= 1'b0;
      len_err_q       <= 1'b0;
      stall_timeout_q <= 1'b0;
    end else begin
      issue_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          stall_cnt <= 8'd0;
          if (bus.req_valid) begin
            len_q       <= clamp_len(bus.req_len);
            idx_q       <= 8'd0;
            if (bus.req_len > MAX_LEN) len_err_q <= 1'b1;
            noc_data_q  <= build_header(bus.req_chipid, bus.req_x, bus.req_y,
                                        clamp_len(bus.req_len), bus.req_type,
                                        bus.req_mshrid);
            noc_valid_q <= 1'b1;
            req_ready_q <= 1'b0;
            state       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (bus.noc_ready_in) begin
            stall_cnt <= 8'd0;
            issue_q   <= 1'b1;
            if (len_q == 8'd0) begin
              done_q      <= 1'b1;
              noc_valid_q <= 1'b0;
              req_ready_q <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              idx_q      <= 8'd0;
              noc_data_q <= data_q[0];
              state      <= ST_PAYLOAD;
            end
          end else begin
            stall_cnt <= stall_inc;
            if (stall_inc >= STALL_LIM) stall_timeout_q <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (bus.noc_ready_in) begin
            stall_cnt <= 8'd0;
            if (idx_q == len_q - 8'd1) begin
              done_q      <= 1'b1;
              noc_valid_q <= 1'b0;
              req_ready_q <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              idx_q      <= idx_nxt;
              noc_data_q <= data_q[idx_nxt[0]];
            end
          end else begin
            stall_cnt <= stall_inc;
            if (stall_inc >= STALL_LIM) stall_timeout_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_noc_msg_injector.sv
// Bench for l2_noc_msg_injector: directed messages, expected flits queued at
// issue time and checked by an independent monitor on the falling edge.
module tb_l2_noc_msg_injector;
  import l2_harness_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_noc_msg_injector_if bus();

  l2_noc_msg_injector #(.MAX_PAYLOAD(2), .STALL_LIMIT(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] data;
    bit          is_hdr;
    bit          is_last;
  } flit_t;

  flit_t exp_q[$];
  flit_t mon_e;
  int    errors = 0;
  int    checks = 0;
  bit    pend_issue = 1'b0;
  bit    pend_done  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_hdr(input logic [13:0] chip, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] len,
                                          input logic [7:0] typ, input logic [7:0] mshr);
    return {chip, x, y, 4'h0, len, typ, mshr, 6'h00};
  endfunction

  // Monitor: pop one expected flit per transfer; pulses follow one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      pend_issue = 1'b0;
      pend_done  = 1'b0;
    end else begin
      if (bus.issue_pulse || pend_issue) check("issue_pulse", 64'(bus.issue_pulse), 64'(pend_issue));
      if (bus.done_pulse  || pend_done)  check("done_pulse",  64'(bus.done_pulse),  64'(pend_done));
      pend_issue = 1'b0;
      pend_done  = 1'b0;
      if (bus.noc_valid_out && bus.noc_ready_in) begin
        if (exp_q.size() == 0) begin
          check("extra_flit", bus.noc_data_out, 64'hDEAD_0000_0000_DEAD);
        end else begin
          mon_e = exp_q.pop_front();
          check("flit_data", bus.noc_data_out, mon_e.data);
          pend_issue = mon_e.is_hdr;
          pend_done  = mon_e.is_last;
        end
      end
    end
  end

  // Issue one request (waits for req_ready), queue its expected flits,
  // then scramble the request fields. Returns 1 time unit into cycle T+1.
  task automatic send(input logic [7:0] typ, input logic [7:0] mshr, input logic [7:0] len,
                      input logic [13:0] chip, input logic [7:0] x, input logic [7:0] y,
                      input logic [127:0] data);
    int          waited;
    logic [7:0]  cl;
    waited = 0;
    while (!bus.req_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) check("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_type   = typ;
    bus.req_mshrid = mshr;
    bus.req_len    = len;
    bus.req_chipid = chip;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_data   = data;
    bus.req_valid  = 1'b1;
    cl = (len > 8'd2) ? 8'd2 : len;
    exp_q.push_back('{data: exp_hdr(chip, x, y, cl, typ, mshr), is_hdr: 1'b1, is_last: (cl == 8'd0)});
    for (int i = 0; i < int'(cl); i++) begin
      exp_q.push_back('{data: data[i*64 +: 64], is_hdr: 1'b0, is_last: (i == int'(cl) - 1)});
    end
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_type   = ~typ;
    bus.req_mshrid = ~mshr;
    bus.req_len    = 8'd1;
    bus.req_chipid = ~chip;
    bus.req_x      = ~x;
    bus.req_y      = ~y;
    bus.req_data   = ~data;
  endtask

  // Wait until every queued flit has been seen and the block is idle again.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.req_ready) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},     64'(bus.req_ready),     64'd1);
    check({tag, "_noc_valid"},     64'(bus.noc_valid_out), 64'd0);
    check({tag, "_noc_data"},      bus.noc_data_out,       64'd0);
    check({tag, "_issue"},         64'(bus.issue_pulse),   64'd0);
    check({tag, "_done"},          64'(bus.done_pulse),    64'd0);
    check({tag, "_len_err"},       64'(bus.len_err),       64'd0);
    check({tag, "_stall_timeout"}, 64'(bus.stall_timeout), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_type   = 8'd0;
    bus.req_mshrid = 8'd0;
    bus.req_len    = 8'd0;
    bus.req_chipid = 14'd0;
    bus.req_x      = 8'd0;
    bus.req_y      = 8'd0;
    bus.req_data   = 128'd0;
    bus.noc_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;

    // Header-only message: header at T+1, both pulses and req_ready at T+2.
    send(MSG_TYPE_STORE_MEM_ACK, 8'h05, 8'd0, 14'h0123, 8'h01, 8'h02, 128'd0);
    @(negedge clk);
    check("t1_hdr_valid", 64'(bus.noc_valid_out), 64'd1);
    check("t1_hdr_data",  bus.noc_data_out, 64'h048C_0408_0006_4140);
    check("t1_req_ready_busy", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("t1_issue", 64'(bus.issue_pulse), 64'd1);
    check("t1_done",  64'(bus.done_pulse),  64'd1);
    check("t1_req_ready", 64'(bus.req_ready), 64'd1);
    check("t1_valid_low", 64'(bus.noc_valid_out), 64'd0);
    wait_idle();

    // Two payload words, no backpressure: three back-to-back flits.
    send(MSG_TYPE_LOAD_MEM_ACK, 8'h11, 8'd2, 14'h0002, 8'h03, 8'h04,
         {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    @(negedge clk);
    check("t2_f0", bus.noc_data_out, exp_hdr(14'h0002, 8'h03, 8'h04, 8'd2, MSG_TYPE_LOAD_MEM_ACK, 8'h11));
    @(negedge clk);
    check("t2_f1", bus.noc_data_out, 64'hAAAA_AAAA_AAAA_AAAA);
    check("t2_f1_valid", 64'(bus.noc_valid_out), 64'd1);
    @(negedge clk);
    check("t2_f2", bus.noc_data_out, 64'hBBBB_BBBB_BBBB_BBBB);
    check("t2_f2_valid", 64'(bus.noc_valid_out), 64'd1);
    @(negedge clk);
    check("t2_done", 64'(bus.done_pulse), 64'd1);
    wait_idle();

    // Backpressure on payload flit 1 for three cycles: held for four.
    send(MSG_TYPE_LOAD_MEM_ACK, 8'h22, 8'd2, 14'h0005, 8'h06, 8'h07,
         {64'h2222_3333_4444_5555, 64'h1111_2222_3333_4444});
    @(posedge clk); #1;
    bus.noc_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_held_data",  bus.noc_data_out, 64'h1111_2222_3333_4444);
      check("t3_held_valid", 64'(bus.noc_valid_out), 64'd1);
      @(posedge clk); #1;
    end
    bus.noc_ready_in = 1'b1;
    @(negedge clk);
    check("t3_held_data4", bus.noc_data_out, 64'h1111_2222_3333_4444);
    wait_idle();
    check("t3_no_timeout", 64'(bus.stall_timeout), 64'd0);

    // Header stalled for 50 cycles: flag rises exactly at the limit, stays set.
    bus.noc_ready_in = 1'b0;
    send(MSG_TYPE_STORE_MEM_ACK, 8'h33, 8'd0, 14'h0001, 8'h00, 8'h00, 128'd0);
    repeat (49) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t4_before_limit", 64'(bus.stall_timeout), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_at_limit", 64'(bus.stall_timeout), 64'd1);
    check("t4_hdr_stable", bus.noc_data_out, exp_hdr(14'h0001, 8'h00, 8'h00, 8'd0, MSG_TYPE_STORE_MEM_ACK, 8'h33));
    @(posedge clk); #1;
    bus.noc_ready_in = 1'b1;
    wait_idle();
    check("t4_sticky", 64'(bus.stall_timeout), 64'd1);

    // Oversized request: clamped to two payload flits, len_err set.
    check("t5_len_err_before", 64'(bus.len_err), 64'd0);
    send(MSG_TYPE_LOAD_MEM_ACK, 8'h44, 8'd7, 14'h3FFF, 8'hFF, 8'h80,
         {64'hDDDD_0000_DDDD_0000, 64'hCCCC_0000_CCCC_0000});
    @(negedge clk);
    check("t5_hdr_len", 64'(bus.noc_data_out[29:22]), 64'd2);
    wait_idle();
    check("t5_len_err", 64'(bus.len_err), 64'd1);

    // Reset during payload flit 1: message dropped, reset values next cycle.
    send(MSG_TYPE_LOAD_MEM_ACK, 8'h55, 8'd2, 14'h0009, 8'h09, 8'h09,
         {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888});
    @(posedge clk); #1;
    bus.noc_ready_in = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.noc_ready_in = 1'b1;
    @(negedge clk);
    check_reset_values("t6");
    @(posedge clk); #1;

    // Recovery after reset: single payload word.
    send(MSG_TYPE_LOAD_MEM_ACK, 8'h66, 8'd1, 14'h0010, 8'h02, 8'h03,
         {64'h0, 64'h0123_4567_89AB_CDEF});
    wait_idle();
    check("t7_len_err_clear", 64'(bus.len_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_noc_msg_injector.md
# l2_noc_msg_injector

Upstream message source for the L2 formal/simulation harness: accepts one abstract coherence message (type, MSHR tag, address, up to two 64-bit payload words), serializes it into OpenPiton-format flits, and drives the L2's NoC input port (noc1 or noc3) under valid/ready flow control. It emits issue and completion pulses so the harness can start its cycle counter and stage monitors exactly when the L2 receives the header. The block holds one message at a time and is not pipelined.

## Interface
- MAX_PAYLOAD, default 2, maximum payload flits per message (header excluded).
- STALL_LIMIT, default 50, backpressure cycles on one flit before stall_timeout asserts.
- Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  message request present.
- req_ready  out  1  block idle and able to accept a request.
- req_type  in  8  message type, header bits [21:14].
- req_mshrid  in  8  MSHR/tag, header bits [13:6].
- req_len  in  8  payload flit count requested.
- req_chipid  in  14  destination chip, header bits [63:50].
- req_x  in  8  destination x, header bits [49:42].
- req_y  in  8  destination y, header bits [41:34].
- req_data  in  128  payload; [63:0] is flit 1, [127:64] is flit 2.
- noc_valid_out  out  1  flit valid toward the L2 (connects to the L2 noc*_valid_in).
- noc_data_out  out  64  flit data (connects to the L2 noc*_data_in).
- noc_ready_in  in  1  L2 ready (connects to the L2 noc*_ready_in output).
- issue_pulse  out  1  one-cycle pulse: header flit accepted.
- done_pulse  out  1  one-cycle pulse: last flit accepted.
- len_err  out  1  sticky: a request had req_len > MAX_PAYLOAD.
- stall_timeout  out  1  sticky: a single flit waited STALL_LIMIT cycles.

## Operation
- Header layout: [63:50] chipid, [49:42] x, [41:34] y, [33:30] fbits = 0, [29:22] payload length (clamped), [21:14] type, [13:6] mshrid, [5:0] options = 0.
- States: IDLE, HDR, PAYLOAD.
- IDLE: req_ready=1, noc_valid_out=0. On req_valid, latch all request fields, clamp len = min(req_len, MAX_PAYLOAD), set len_err if clamped, go to HDR.
- HDR: noc_valid_out=1, noc_data_out=header. On noc_ready_in: pulse issue_pulse; if len==0, pulse done_pulse and go to IDLE, otherwise go to PAYLOAD with flit index 0.
- PAYLOAD: noc_data_out = latched data word[idx]. On noc_ready_in: if idx==len-1, pulse done_pulse and go to IDLE, otherwise idx+1.
- Stall counter: 8-bit; clears on every flit transfer and in IDLE; increments while noc_valid_out && !noc_ready_in; saturates at 255. stall_timeout sets when the counter reaches STALL_LIMIT.
- Request fields are sampled only in the accepting cycle; later changes have no effect on the message in flight.

## Timing
- Reset values: req_ready=1, noc_valid_out=0, noc_data_out=0, issue_pulse=0, done_pulse=0, len_err=0, stall_timeout=0, state IDLE.
- Request accepted in cycle T; header valid from T+1.
- Zero backpressure: message occupies len+1 cycles on the NoC, then 1 IDLE cycle. Minimum request-to-request spacing is len+2 cycles; there is no same-cycle re-accept.
- noc_data_out and noc_valid_out are registered and stay stable while valid && !ready.
- issue_pulse and done_pulse are registered and assert in the cycle after the corresponding transfer. For len==0 both assert in the same cycle.
- rst mid-message: the message is dropped and noc_valid_out=0 in the cycle after rst. The L2 then sees a truncated message; the harness resets the L2 with the injector.
- Sticky flags clear only on rst.

## Structure
- Shared package l2_harness_pkg holds:
  - header field bit-position constants;
  - the injector state enum;
  - message type constants, e.g. MSG_TYPE_STORE_MEM_ACK, MSG_TYPE_LOAD_MEM_ACK.
- Single module, no sub-module; the flit mux is inline.

## Test plan
- rst, then type=STORE_MEM_ACK, mshrid=0x05, len=0, noc_ready_in=1 -> header only at T+1 with [21:14]=type and [29:22]=0; issue_pulse and done_pulse both at T+2; req_ready=1 at T+2.
- len=2, data={0xBBBB…,0xAAAA…}, ready=1 -> flits: header, 0xAAAA…, 0xBBBB… on consecutive cycles; done_pulse 1 cycle after the third flit.
- len=2, noc_ready_in low for 3 cycles on payload flit 1 -> flit held stable for 4 cycles; no extra flits; stall_timeout=0.
- noc_ready_in held low for 50 cycles on the header -> stall_timeout=1 and stays 1 after ready returns.
- req_len=7 -> header length field = 2; exactly 2 payload flits sent; len_err=1.
- rst asserted during payload flit 1 -> noc_valid_out=0 next cycle; req_ready=1; all outputs at reset values.
